bus_arb: RTL and testbench
==========================

# bus_arb

Two-master arbiter that shares the single bexkat1 memory bus between the instruction-fetch stage (master 0) and the memory stage (master 1). It sits between the pipeline and the bus slave side, forwards the granted master's cycle, and routes ack/data back to it. It also terminates hung cycles with an error pulse after a timeout, and stops data traffic from starving instruction fetch.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive waiting cycles of master 0 after which it overrides master 1 priority; range 1..15.
- TIMEOUT, 255: granted cycles without `s_ack_i` before forced termination; range 1..255, 8-bit counter.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  input  1  clock; all state changes on rising edge
- rst_ni  input  1  asynchronous active-low reset
- m0_cyc_i, m1_cyc_i  input  1  master request; held until ack/err
- m0_we_i, m1_we_i  input  1  write enable
- m0_adr_i, m1_adr_i  input  32  byte address
- m0_sel_i, m1_sel_i  input  4  byte lanes
- m0_dat_i, m1_dat_i  input  32  write data
- m0_ack_o, m1_ack_o  output  1  transfer complete to that master
- m0_err_o, m1_err_o  output  1  timeout termination to that master
- m_dat_o  output  32  read data, equals `s_dat_i`, broadcast to both masters
- s_cyc_o, s_we_o  output  1  slave-side cycle and write enable
- s_adr_o  output  32  slave-side address
- s_sel_o  output  4  slave-side byte lanes
- s_dat_o  output  32  slave-side write data
- s_ack_i  input  1  slave acknowledge
- s_dat_i  input  32  slave read data
- grant_o  output  2  one-hot current owner: 01 is m0, 10 is m1, 00 is idle

## Operation
- States: IDLE, GNT0, GNT1. Reset forces IDLE, grant_o=00, both counters 0.
- IDLE: the requests are sampled, and the next state is decided as follows.
  - Only m0 requests: go to GNT0.
  - Only m1 requests: go to GNT1.
  - Both request: go to GNT0 if starve_cnt ≥ STARVE_MAX, otherwise GNT1 (data has priority).
  - Neither requests: stay in IDLE.
- GNTx: slave outputs are combinationally muxed from master x.
  - `s_cyc_o = mx_cyc_i & ~timeout_hit`.
  - `mx_ack_o = s_ack_i`. The non-owner ack/err are always 0.
- Leaving GNTx, each case returning to IDLE on the next edge:
  - `s_ack_i`.
  - `mx_cyc_i` dropped (abort): `s_cyc_o` falls the same cycle, and no ack is forwarded afterwards.
  - Timeout hit.
- Timeout: to_cnt clears on entering GNTx and increments each GNTx cycle without ack.
  - When to_cnt == TIMEOUT-1 and no ack: timeout_hit=1 and `mx_err_o` pulses for that one cycle, with `s_cyc_o` forced 0.
  - Ack and timeout in the same cycle: ack wins and err stays 0.
- Starvation: starve_cnt (4-bit, saturating at 15) increments each cycle `m0_cyc_i` is high and grant_o≠01. It clears on entry to GNT0 and whenever `m0_cyc_i` is low.
- In IDLE all `s_*` outputs are 0. `s_adr_o`, `s_dat_o`, `s_sel_o` and `s_we_o` are 0 whenever grant_o=00.
- Reset assertion mid-cycle: it immediately forces IDLE and all outputs to 0, and the outstanding transfer is dropped without ack or err.

## Timing
- Arbitration latency is 1 cycle: request in cycle n gives grant_o and `s_cyc_o` in cycle n+1.
- Ack passes combinationally from `s_ack_i` to `mx_ack_o` in the same cycle. `m_dat_o` is valid in the ack cycle.
- There is one mandatory IDLE cycle after every termination. Peak rate is 1 transfer per 2 cycles, zero-wait slave.
- grant_o, state and counters are registered. Slave outputs, acks and err are combinational from state plus inputs.
- A master must hold cyc/adr/we/sel/dat stable until its ack or err. A new request may be raised in the cycle after ack.

## Test plan
- Single m1 read, adr 0x00001000, slave acks in its 3rd granted cycle with s_dat_i 0xDEADBEEF. Required:
  - grant_o=10 from cycle 1.
  - m1_ack_o and m_dat_o=0xDEADBEEF in cycle 3.
  - IDLE in cycle 4.
- Both masters request continuously, zero-wait slave, STARVE_MAX=4. Required:
  - m1 wins each arbitration until starve_cnt reaches 4.
  - Then GNT0 is entered, m0 is acked, and starve_cnt is 0.
  - The pattern repeats with no deadlock.
- m0 write, slave never acks, TIMEOUT=8. Required:
  - m0_err_o pulses exactly 1 cycle, in granted cycle 8.
  - s_cyc_o=0 in that cycle, m0_ack_o never 1, IDLE next cycle.
- s_ack_i and timeout coincide on cycle TIMEOUT. Required: ack forwarded, err 0.
- m1 drops cyc in its 2nd granted cycle before ack. Required:
  - s_cyc_o falls the same cycle and no ack is forwarded.
  - Pending m0 is granted 2 cycles later.
- rst_ni pulled low mid-GNT1. Required:
  - All outputs 0 asynchronously and grant_o=00.
  - After release, the m1 request is re-arbitrated and completes normally.

Source files
------------

// File: rtl/bus_arb.sv
// Two-master arbiter for the shared bexkat1 memory bus: fetch (m0) versus memory stage (m1).
// Data has priority unless fetch has waited STARVE_MAX cycles; hung cycles are ended by an error pulse.
module bus_arb #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_cyc_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m1_cyc_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_dat_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m_dat_o,
    output logic        s_cyc_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_to_cnt;
    logic [3:0] r_starve_cnt;
    logic       w_own_cyc;
    logic       w_timeout_hit;
    logic       w_done;

    always_comb begin
        w_own_cyc = 1'b0;
        case (r_state)
            GNT0:    w_own_cyc = m0_cyc_i;
            GNT1:    w_own_cyc = m1_cyc_i;
            default: w_own_cyc = 1'b0;
        endcase
    end

    // An ack in the last allowed cycle beats the timeout.
    assign w_timeout_hit = w_own_cyc & ~s_ack_i & (r_to_cnt == TO_LAST);
    assign w_done        = s_ack_i | ~w_own_cyc | w_timeout_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_next = (r_starve_cnt >= STARVE_LIM) ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    w_state_next = GNT0;
                end else if (m1_cyc_i) begin
                    w_state_next = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (w_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_sel_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (r_state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i & ~w_timeout_hit;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_sel_o  = m0_sel_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i & m0_cyc_i;
                m0_err_o = w_timeout_hit;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i & ~w_timeout_hit;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_sel_o  = m1_sel_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i & m1_cyc_i;
                m1_err_o = w_timeout_hit;
            end
            default: ;
        endcase
    end

    assign grant_o = {r_state == GNT1, r_state == GNT0};
    assign m_dat_o = s_dat_i;

    // Timeout counter is held at zero in IDLE so every grant starts fresh.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_to_cnt     <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (r_state == IDLE) begin
                r_to_cnt <= '0;
            end else if (!s_ack_i) begin
                r_to_cnt <= r_to_cnt + 8'd1;
            end

            if (!m0_cyc_i) begin
                r_starve_cnt <= '0;
            end else if (r_state == IDLE && w_state_next == GNT0) begin
                r_starve_cnt <= '0;
            end else if (r_state != GNT0 && r_starve_cnt != 4'hF) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb: stimulus pushes expected terminations into a queue,
// a negedge monitor pops one entry for every ack/err the arbiter presents.
module tb_bus_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_we, m1_cyc, m1_we;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m_dat;
    logic        s_cyc, s_we;
    logic [31:0] s_adr, s_dat_o;
    logic [3:0]  s_sel;
    logic        s_ack;
    logic [31:0] s_dat_i;
    logic [1:0]  grant;
    logic        auto_ack, man_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        master;
        logic        err;
        logic [31:0] dat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Zero-wait slave when auto_ack is set, otherwise acks are placed by hand.
    assign s_ack = auto_ack ? s_cyc : man_ack;

    bus_arb #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_cyc_i(m0_cyc), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_sel_i(m0_sel), .m0_dat_i(m0_dat),
        .m1_cyc_i(m1_cyc), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_sel_i(m1_sel), .m1_dat_i(m1_dat),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .m_dat_o(m_dat),
        .s_cyc_o(s_cyc), .s_we_o(s_we), .s_adr_o(s_adr), .s_sel_o(s_sel), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack), .s_dat_i(s_dat_i),
        .grant_o(grant)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic push(input logic master, input logic err, input logic [31:0] dat);
        exp_t e;
        e.master = master;
        e.err    = err;
        e.dat    = dat;
        sb.push_back(e);
    endtask

    // Monitor: every termination seen at a master must match the queue head.
    always @(negedge clk) begin
        if (rst_n && (m0_ack || m0_err || m1_ack || m1_err)) begin
            exp_t e;
            logic gm, ge;
            gm = m1_ack | m1_err;
            ge = m0_err | m1_err;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected actual=m%0d err=%0d required=none", gm, ge);
            end else begin
                e = sb.pop_front();
                if (gm !== e.master || ge !== e.err || (!e.err && m_dat !== e.dat)) begin
                    errors++;
                    $display("FAIL sb_term actual=m%0d err=%0d dat=%h required=m%0d err=%0d dat=%h",
                             gm, ge, m_dat, e.master, e.err, e.dat);
                end else begin
                    $display("txn m%0d %s dat=%h t=%0t", gm, ge ? "err" : "ack", m_dat, $time);
                end
            end
        end
    end

    initial begin
        int exp_g[6] = '{2, 0, 2, 0, 1, 0};
        int eg;
        rst_n = 1'b0;
        {m0_cyc, m0_we, m1_cyc, m1_we} = '0;
        m0_adr = '0; m0_dat = '0; m0_sel = '0;
        m1_adr = '0; m1_dat = '0; m1_sel = '0;
        auto_ack = 1'b0; man_ack = 1'b0; s_dat_i = '0;
        #3;
        chk("rst_grant", grant, 2'b00);
        chk("rst_scyc", s_cyc, 1'b0);
        tick(); tick();
        rst_n = 1'b1;

        // Single m1 read, ack in third granted cycle.
        tick(); m1_cyc = 1; m1_adr = 32'h0000_1000; m1_we = 0; m1_sel = 4'hF; settle();
        chk("t1_c0_grant", grant, 2'b00);
        tick(); settle();
        chk("t1_c1_grant", grant, 2'b10);
        chk("t1_c1_scyc", s_cyc, 1'b1);
        chk("t1_c1_sadr", s_adr, 32'h0000_1000);
        tick(); settle();
        chk("t1_c2_ack", m1_ack, 1'b0);
        tick(); man_ack = 1; s_dat_i = 32'hDEAD_BEEF; push(1'b1, 1'b0, 32'hDEAD_BEEF); settle();
        chk("t1_c3_ack", m1_ack, 1'b1);
        chk("t1_c3_mdat", m_dat, 32'hDEAD_BEEF);
        chk("t1_c3_ack0", m0_ack, 1'b0);
        tick(); man_ack = 0; m1_cyc = 0; settle();
        chk("t1_c4_grant", grant, 2'b00);
        chk("t1_c4_sadr", s_adr, 32'h0);

        // Both request continuously with a zero-wait slave: m1, m1, m0, repeat.
        tick(); m0_cyc = 1; m0_adr = 32'h0000_0100; m1_cyc = 1; m1_adr = 32'h0000_2000;
        auto_ack = 1; s_dat_i = 32'h5A5A_0000; settle();
        chk("t2_c0_grant", grant, 2'b00);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 12) begin
                m0_cyc = 0; m1_cyc = 0;
            end
            settle();
            eg = exp_g[(c - 1) % 6];
            if (eg != 0) push((eg == 2), 1'b0, 32'h5A5A_0000);
            chk($sformatf("t2_c%0d_grant", c), grant, eg[1:0]);
        end
        auto_ack = 0;

        // m0 write with no ack: error in granted cycle 8.
        tick(); m0_cyc = 1; m0_we = 1; m0_adr = 32'h0000_0040; m0_dat = 32'h1234_5678; m0_sel = 4'h3; settle();
        for (int g = 1; g <= 7; g++) begin
            tick(); settle();
            chk($sformatf("t3_g%0d_scyc", g), s_cyc, 1'b1);
            chk($sformatf("t3_g%0d_err", g), m0_err, 1'b0);
        end
        chk("t3_swe", s_we, 1'b1);
        chk("t3_sdat", s_dat_o, 32'h1234_5678);
        chk("t3_ssel", s_sel, 4'h3);
        tick(); push(1'b0, 1'b1, 32'h0); settle();
        chk("t3_g8_err", m0_err, 1'b1);
        chk("t3_g8_scyc", s_cyc, 1'b0);
        chk("t3_g8_ack", m0_ack, 1'b0);
        tick(); m0_cyc = 0; m0_we = 0; settle();
        chk("t3_idle_grant", grant, 2'b00);
        chk("t3_idle_err", m0_err, 1'b0);

        // Ack coinciding with the timeout cycle wins.
        tick(); m1_cyc = 1; m1_adr = 32'h0000_3000; settle();
        for (int g = 1; g <= 7; g++) tick();
        tick(); man_ack = 1; s_dat_i = 32'hCAFE_F00D; push(1'b1, 1'b0, 32'hCAFE_F00D); settle();
        chk("t4_ack", m1_ack, 1'b1);
        chk("t4_err", m1_err, 1'b0);
        chk("t4_scyc", s_cyc, 1'b1);
        tick(); man_ack = 0; m1_cyc = 0; settle();
        chk("t4_idle_grant", grant, 2'b00);

        // m1 aborts in its 2nd granted cycle; pending m0 granted two cycles later.
        tick(); m0_cyc = 1; m1_cyc = 1; settle();
        tick(); settle();
        chk("t5_c1_grant", grant, 2'b10);
        tick(); m1_cyc = 0; settle();
        chk("t5_c2_scyc", s_cyc, 1'b0);
        chk("t5_c2_ack", m1_ack, 1'b0);
        tick(); settle();
        chk("t5_c3_grant", grant, 2'b00);
        tick(); man_ack = 1; s_dat_i = 32'h0BAD_F00D; push(1'b0, 1'b0, 32'h0BAD_F00D); settle();
        chk("t5_c4_grant", grant, 2'b01);
        chk("t5_c4_ack", m0_ack, 1'b1);
        tick(); man_ack = 0; m0_cyc = 0; settle();

        // Asynchronous reset in the middle of a GNT1 cycle.
        tick(); m1_cyc = 1; m1_we = 1; m1_adr = 32'h0000_4000; s_dat_i = 32'h0; settle();
        tick(); settle();
        chk("t6_c1_grant", grant, 2'b10);
        tick(); #2; rst_n = 0; #1;
        chk("t6_rst_grant", grant, 2'b00);
        chk("t6_rst_scyc", s_cyc, 1'b0);
        chk("t6_rst_sadr", s_adr, 32'h0);
        chk("t6_rst_swe", s_we, 1'b0);
        chk("t6_rst_ack", m1_ack | m1_err, 1'b0);
        tick(); rst_n = 1; settle();
        chk("t6_rel_grant", grant, 2'b00);
        tick(); man_ack = 1; s_dat_i = 32'h7777_0001; push(1'b1, 1'b0, 32'h7777_0001); settle();
        chk("t6_re_grant", grant, 2'b10);
        chk("t6_re_ack", m1_ack, 1'b1);
        tick(); man_ack = 0; m1_cyc = 0; m1_we = 0; settle();
        chk("t6_end_grant", grant, 2'b00);

        tick(); settle();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
